// File: rtl/sfft_frame_readout.sv
// Ping-pong spectral frame buffer: the SFFT stream fills the back bank while software reads the
// front bank over a byte-wide bus. A lock bit freezes the front bank and the counter view.
module sfft_frame_readout #(
  parameter int NFFT_LOG2   = 9,
  parameter int CHANNELS    = 2,
  parameter int BIN_WIDTH   = 24,
  parameter int ADDR_WIDTH  = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               in_valid,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] in_channel,
  input  logic [NFFT_LOG2-1:0]                               in_bin,
  input  logic [BIN_WIDTH-1:0]                               in_data,
  input  logic                                               in_last,
  input  logic                                               chipselect,
  input  logic                                               write,
  input  logic [7:0]                                         writedata,
  input  logic [ADDR_WIDTH-1:0]                              address,
  output logic [7:0]                                         readdata,
  output logic                                               frame_irq
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NBINS = 1 << NFFT_LOG2;
  localparam int DEPTH = CHANNELS * NBINS;
  localparam int WW    = CH_W + NFFT_LOG2;
  localparam logic [ADDR_WIDTH-1:0]  BASE_A  = ADDR_WIDTH'(DEPTH * 4);
  localparam logic [ADDR_WIDTH-1:0]  CTRL_A  = ADDR_WIDTH'(DEPTH * 4 + 8);
  localparam logic [CH_W:0]          CH_LIM  = (CH_W + 1)'(CHANNELS);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [BIN_WIDTH-1:0] bank0 [0:DEPTH-1];
  logic [BIN_WIDTH-1:0] bank1 [0:DEPTH-1];

  // bank_sel names the back (write) bank; the front bank is the other one.
  logic                   bank_sel, locked, pending, front_valid, frame_open;
  logic [COUNT_WIDTH-1:0] frame_count, drop_count, frame_shadow, drop_shadow;

  logic            sample_ok, frame_end, frame_start, pend_swap, swap, wr_bank;
  logic            ctrl_wr, rd_en;
  logic [WW-1:0]   wr_idx, rd_idx;
  logic [31:0]     word, fview, dview;
  logic [ADDR_WIDTH-1:0] offset;
  logic [7:0]      rd_byte;
  logic            unused_ok;

  assign sample_ok   = in_valid & ({1'b0, in_channel} < CH_LIM);
  assign frame_end   = sample_ok & in_last;
  assign frame_start = sample_ok & ~frame_open;
  assign pend_swap   = pending & ~locked;
  assign swap        = pend_swap | (frame_end & ~locked);
  // A pending bank promoted on this edge must not receive the opening sample of the next frame.
  assign wr_bank     = bank_sel ^ pend_swap;
  assign wr_idx      = {in_channel, in_bin};
  assign rd_idx      = address[WW+1:2];
  assign ctrl_wr     = chipselect & write & (address == CTRL_A);
  assign rd_en       = chipselect & ~write;
  assign offset      = address - BASE_A;
  assign fview       = locked ? 32'(frame_shadow) : 32'(frame_count);
  assign dview       = locked ? 32'(drop_shadow)  : 32'(drop_count);
  assign unused_ok   = ^writedata[7:1];

  always_ff @(posedge clk) begin
    if (sample_ok) begin
      if (wr_bank) bank1[wr_idx] <= in_data;
      else         bank0[wr_idx] <= in_data;
    end
  end

  always_comb begin
    rd_byte = '0;
    word    = '0;
    if (address < BASE_A) begin
      word    = bank_sel ? 32'(bank0[rd_idx]) : 32'(bank1[rd_idx]);
      rd_byte = word[{address[1:0], 3'b000} +: 8];
    end else if (offset < ADDR_WIDTH'(4)) begin
      rd_byte = fview[{offset[1:0], 3'b000} +: 8];
    end else if (offset < ADDR_WIDTH'(8)) begin
      rd_byte = dview[{offset[1:0], 3'b000} +: 8];
    end else if (offset == ADDR_WIDTH'(8)) begin
      rd_byte = {5'b0, locked, pending, front_valid};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_sel     <= 1'b0;
      locked       <= 1'b0;
      pending      <= 1'b0;
      front_valid  <= 1'b0;
      frame_open   <= 1'b0;
      frame_count  <= '0;
      drop_count   <= '0;
      frame_shadow <= '0;
      drop_shadow  <= '0;
      readdata     <= '0;
      frame_irq    <= 1'b0;
    end else begin
      bank_sel    <= bank_sel ^ swap;
      frame_irq   <= swap;
      front_valid <= front_valid | swap;
      if (swap) frame_count <= frame_count + 1'b1;
      if (sample_ok) frame_open <= ~in_last;
      // Opening a frame over an unpromoted pending bank loses that frame.
      if (frame_start & pending & ~pend_swap & (drop_count != CNT_MAX))
        drop_count <= drop_count + 1'b1;
      pending <= (pending & ~pend_swap & ~frame_start) | (frame_end & locked);
      if (ctrl_wr) begin
        locked <= writedata[0];
        if (writedata[0] & ~locked) begin
          frame_shadow <= frame_count;
          drop_shadow  <= drop_count;
        end
      end
      if (rd_en) readdata <= rd_byte;
    end
  end
endmodule

// File: tb/tb_sfft_frame_readout.sv
// Randomized bench for sfft_frame_readout against a front/back frame model kept in the bench.
module tb_sfft_frame_readout;
  localparam int NB   = 512;
  localparam int NW   = 1024;
  localparam int BASE = 4096;
  localparam logic [15:0] CTRL = 16'(BASE + 8);

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_last, chipselect, write;
  logic [0:0]  in_channel;
  logic [8:0]  in_bin;
  logic [23:0] in_data;
  logic [7:0]  writedata, readdata;
  logic [15:0] address;
  logic        frame_irq;

  sfft_frame_readout dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_channel(in_channel), .in_bin(in_bin),
    .in_data(in_data), .in_last(in_last), .chipselect(chipselect), .write(write),
    .writedata(writedata), .address(address), .readdata(readdata), .frame_irq(frame_irq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: two frame stores with front/back roles, plus counters and flags.
  logic [23:0] m_mem [0:1][0:NW-1];
  bit          m_kn  [0:1][0:NW-1];
  bit          m_front_b, m_locked, m_pending, m_fvalid, m_open;
  int unsigned m_frame, m_drop, m_sf, m_sd;
  logic        irq_at_end, irq_after;

  task automatic model_reset();
    m_front_b = 1'b1; m_locked = 0; m_pending = 0; m_fvalid = 0; m_open = 0;
    m_frame = 0; m_drop = 0; m_sf = 0; m_sd = 0;
    for (int b = 0; b < 2; b++) for (int w = 0; w < NW; w++) m_kn[b][w] = 1'b0;
  endtask

  task automatic model_swap();
    m_front_b = ~m_front_b;
    m_frame   = m_frame + 1;
    m_fvalid  = 1'b1;
  endtask

  task automatic model_sample(input int ch, input int bin, input logic [23:0] d, input bit last);
    if (!m_open && m_pending) begin
      m_pending = 1'b0;
      if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
    end
    m_open = !last;
    m_mem[!m_front_b][ch*NB + bin] = d;
    m_kn[!m_front_b][ch*NB + bin]  = 1'b1;
    if (last) begin
      if (m_locked) m_pending = 1'b1;
      else model_swap();
    end
  endtask

  function automatic bit model_known(input logic [15:0] a);
    if (a >= 16'(BASE)) return 1'b1;
    return m_fvalid && m_kn[m_front_b][a >> 2];
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    int unsigned o, fv, dv;
    logic [31:0] w;
    if (a < 16'(BASE)) begin
      w = 32'(m_mem[m_front_b][a >> 2]);
      return 8'(w >> (8 * a[1:0]));
    end
    o  = 32'(a) - BASE;
    fv = m_locked ? m_sf : m_frame;
    dv = m_locked ? m_sd : m_drop;
    if (o < 4) return 8'(fv >> (8 * o));
    if (o < 8) return 8'(dv >> (8 * (o - 4)));
    if (o == 8) return {5'b0, m_locked, m_pending, m_fvalid};
    return 8'h00;
  endfunction

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    chipselect = 1'b1; write = 1'b0; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0;
    d = readdata;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] wd);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = wd;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
    if (a == CTRL) begin
      if (wd[0] && !m_locked) begin m_sf = m_frame; m_sd = m_drop; end
      m_locked = wd[0];
    end
  endtask

  task automatic drive_run(input int first, input int count, input bit last_at_end, input bit pattern);
    for (int i = 0; i < count; i++) begin
      int idx = first + i;
      int ch  = idx / NB;
      int bin = idx % NB;
      bit last = last_at_end && (i == count - 1);
      logic [23:0] d;
      if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
      d = pattern ? 24'((ch << 8) | bin) : 24'($urandom);
      in_valid = 1'b1; in_channel = 1'(ch); in_bin = 9'(bin); in_data = d; in_last = last;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      model_sample(ch, bin, d, last);
      if (last) begin
        irq_at_end = frame_irq;
        @(posedge clk); #1;
        irq_after = frame_irq;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    model_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (readdata !== 8'h00 || frame_irq !== 1'b0) begin
      errors++; $display("FAIL reset_outputs readdata=%h irq=%b want 00/0", readdata, frame_irq);
    end
    reset = 1'b1;
    bus_read(CTRL, got);
    vectors++;
    if (got !== model_read(CTRL)) begin
      errors++; $display("FAIL reset_status got=%h want=%h", got, model_read(CTRL));
    end
    bus_read(16'h0000, got);
    for (int k = 0; k < 8; k++) begin
      bus_read(16'(BASE + k), got);
      vectors++;
      if (got !== model_read(16'(BASE + k))) begin
        errors++; $display("FAIL reset_counter byte=%0d got=%h want=%h", k, got, model_read(16'(BASE + k)));
      end
    end
  endtask

  task automatic test_stream();
    logic [7:0] got, exp;
    logic [15:0] a;
    drive_run(0, NW, 1, 1);
    vectors++;
    if (irq_at_end !== 1'b1 || irq_after !== 1'b0) begin
      errors++; $display("FAIL stream_irq got=%b%b want=10", irq_at_end, irq_after);
    end
    for (int k = 0; k < 4; k++) begin
      a = 16'(4 * (NB + 5) + k);
      bus_read(a, got);
      exp = model_read(a);
      vectors++;
      if (got !== exp) begin
        errors++; $display("FAIL stream_word a=%h got=%h want=%h", a, got, exp);
      end
    end
    for (int k = 0; k < 16; k++) begin
      a = 16'($urandom_range(0, BASE - 1));
      bus_read(a, got);
      exp = model_read(a);
      vectors++;
      if (got !== exp) begin
        errors++; $display("FAIL stream_front a=%h got=%h want=%h", a, got, exp);
      end
    end
    bus_write(16'(BASE), 8'h01);
    bus_read(16'(BASE), got);
    exp = model_read(16'(BASE));
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (got !== exp || readdata !== exp) begin
      errors++; $display("FAIL stream_count_hold got=%h held=%h want=%h", got, readdata, exp);
    end
    bus_read(CTRL, got);
    vectors++;
    if (got !== model_read(CTRL)) begin
      errors++; $display("FAIL stream_status got=%h want=%h", got, model_read(CTRL));
    end
    bus_read(16'hFFFF, got);
    vectors++;
    if (got !== 8'h00) begin
      errors++; $display("FAIL stream_unmapped got=%h want=00", got);
    end
  endtask

  task automatic test_lock_pending();
    logic [7:0] got, exp;
    logic [15:0] a;
    bus_write(CTRL, 8'h01);
    drive_run(0, NW, 1, 0);
    vectors++;
    if (irq_at_end !== 1'b0 || irq_after !== 1'b0) begin
      errors++; $display("FAIL locked_irq got=%b%b want=00", irq_at_end, irq_after);
    end
    bus_read(CTRL, got);
    vectors++;
    if (got !== model_read(CTRL)) begin
      errors++; $display("FAIL locked_status got=%h want=%h", got, model_read(CTRL));
    end
    for (int k = 0; k < 8; k++) begin
      a = 16'($urandom_range(0, BASE - 1));
      bus_read(a, got);
      exp = model_read(a);
      vectors++;
      if (got !== exp) begin
        errors++; $display("FAIL locked_front a=%h got=%h want=%h", a, got, exp);
      end
    end
    bus_write(CTRL, 8'h00);
    @(posedge clk); #1;
    vectors++;
    if (frame_irq !== m_pending) begin
      errors++; $display("FAIL unlock_irq got=%b want=%b", frame_irq, m_pending);
    end
    if (m_pending) begin m_pending = 1'b0; model_swap(); end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      bus_read(16'(BASE + k), got);
      vectors++;
      if (got !== model_read(16'(BASE + k))) begin
        errors++; $display("FAIL unlock_count byte=%0d got=%h want=%h", k, got, model_read(16'(BASE + k)));
      end
    end
    bus_read(CTRL, got);
    vectors++;
    if (got !== model_read(CTRL)) begin
      errors++; $display("FAIL unlock_status got=%h want=%h", got, model_read(CTRL));
    end
    for (int k = 0; k < 8; k++) begin
      a = 16'($urandom_range(0, BASE - 1));
      bus_read(a, got);
      exp = model_read(a);
      vectors++;
      if (got !== exp) begin
        errors++; $display("FAIL unlock_front a=%h got=%h want=%h", a, got, exp);
      end
    end
  endtask

  task automatic test_overwrite();
    logic [7:0] got, exp;
    logic [15:0] a;
    bus_write(CTRL, 8'h01);
    drive_run(0, NW, 1, 0);
    drive_run(0, 100, 0, 0);
    bus_read(CTRL, got);
    vectors++;
    if (got !== model_read(CTRL)) begin
      errors++; $display("FAIL overwrite_status got=%h want=%h", got, model_read(CTRL));
    end
    bus_read(16'(BASE + 4), got);
    vectors++;
    if (got !== model_read(16'(BASE + 4))) begin
      errors++; $display("FAIL overwrite_shadow_drop got=%h want=%h", got, model_read(16'(BASE + 4)));
    end
    bus_write(CTRL, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (frame_irq !== 1'b0) begin
        errors++; $display("FAIL overwrite_no_swap cycle=%0d irq=%b want=0", k, frame_irq);
      end
    end
    for (int k = 0; k < 8; k++) begin
      bus_read(16'(BASE + k), got);
      vectors++;
      if (got !== model_read(16'(BASE + k))) begin
        errors++; $display("FAIL overwrite_counters byte=%0d got=%h want=%h", k, got, model_read(16'(BASE + k)));
      end
    end
    drive_run(100, NW - 100, 1, 0);
    vectors++;
    if (irq_at_end !== 1'b1 || irq_after !== 1'b0) begin
      errors++; $display("FAIL overwrite_finish_irq got=%b%b want=10", irq_at_end, irq_after);
    end
    for (int k = 0; k < 8; k++) begin
      a = 16'($urandom_range(0, BASE - 1));
      bus_read(a, got);
      exp = model_read(a);
      vectors++;
      if (got !== exp) begin
        errors++; $display("FAIL overwrite_front a=%h got=%h want=%h", a, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back_shadow();
    logic [7:0] got, exp;
    while (m_frame != 32'hFF) begin
      drive_run($urandom_range(0, NW - 1), 1, 1, 0);
      vectors++;
      if (irq_at_end !== 1'b1 || irq_after !== 1'b0) begin
        errors++; $display("FAIL b2b_irq frame=%0d got=%b%b want=10", m_frame, irq_at_end, irq_after);
      end
    end
    bus_write(CTRL, 8'h01);
    drive_run($urandom_range(0, NW - 1), 1, 1, 0);
    drive_run($urandom_range(0, NW - 1), 1, 1, 0);
    for (int k = 0; k < 9; k++) begin
      bus_read(16'(BASE + k), got);
      exp = model_read(16'(BASE + k));
      vectors++;
      if (got !== exp) begin
        errors++; $display("FAIL shadow_view off=%0d got=%h want=%h", k, got, exp);
      end
    end
    bus_write(CTRL, 8'h00);
    @(posedge clk); #1;
    vectors++;
    if (frame_irq !== 1'b1) begin
      errors++; $display("FAIL shadow_unlock_irq got=%b want=1", frame_irq);
    end
    m_pending = 1'b0;
    model_swap();
    for (int k = 0; k < 8; k++) begin
      bus_read(16'(BASE + k), got);
      exp = model_read(16'(BASE + k));
      vectors++;
      if (got !== exp) begin
        errors++; $display("FAIL live_view off=%0d got=%h want=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, exp;
    logic [15:0] a;
    bus_write(CTRL, 8'h01);
    drive_run(0, NW, 1, 0);
    bus_read(CTRL, got);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (readdata !== 8'h00 || frame_irq !== 1'b0) begin
      errors++; $display("FAIL async_reset readdata=%h irq=%b want 00/0", readdata, frame_irq);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    drive_run(0, 200, 0, 0);
    #3;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus_read(16'(BASE + k), got);
      vectors++;
      if (got !== model_read(16'(BASE + k))) begin
        errors++; $display("FAIL reset_mid_regs off=%0d got=%h want=%h", k, got, model_read(16'(BASE + k)));
      end
    end
    drive_run(0, NW, 1, 0);
    vectors++;
    if (irq_at_end !== 1'b1 || irq_after !== 1'b0) begin
      errors++; $display("FAIL reset_mid_irq got=%b%b want=10", irq_at_end, irq_after);
    end
    for (int k = 0; k < 9; k++) begin
      bus_read(16'(BASE + k), got);
      vectors++;
      if (got !== model_read(16'(BASE + k))) begin
        errors++; $display("FAIL reset_mid_after off=%0d got=%h want=%h", k, got, model_read(16'(BASE + k)));
      end
    end
    for (int k = 0; k < 8; k++) begin
      a = 16'($urandom_range(0, BASE - 1));
      bus_read(a, got);
      exp = model_read(a);
      if (model_known(a)) begin
        vectors++;
        if (got !== exp) begin
          errors++; $display("FAIL reset_mid_front a=%h got=%h want=%h", a, got, exp);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_channel = '0; in_bin = '0; in_data = '0;
    chipselect = 1'b0; write = 1'b0; writedata = '0; address = '0;
    irq_at_end = 1'b0; irq_after = 1'b0;
    #1;
    test_reset();
    test_stream();
    test_lock_pending();
    test_overwrite();
    test_back_to_back_shadow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
